// File: rtl/transmission_status_tracker.sv
// Run-state tracker for the streaming data generator.
// Packs state and statistics into the 11-word status bus.
module transmission_status_tracker #(
    parameter int          NUM_STATUS_REGS = 11,
    parameter logic [31:0] VERSION         = 32'h0001_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ctrl_enable,
    input  logic                           ctrl_clear_counters,
    input  logic [31:0]                    loop_limit,
    input  logic                           frame_done,
    input  logic                           fifo_write,
    input  logic                           fifo_full,
    output logic [32*NUM_STATUS_REGS-1:0]  status_regs_pl,
    output logic                           transmission_active,
    output logic                           loop_limit_reached
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        start;
    logic        running;
    logic        overflow;
    logic [31:0] frame_next;

    logic [31:0] latched_limit;
    logic [31:0] frame_count;
    logic [31:0] overflow_count;
    logic        overflow_sticky;
    logic [63:0] run_cycles;
    logic [31:0] start_count;

    // Next-state decode; stop requests take priority over the limit check.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        running    = 1'b0;
        frame_next = frame_count + 32'd1;
        unique case (state)
            IDLE: begin
                if (ctrl_enable) begin
                    state_next = RUNNING;
                    start      = 1'b1;
                end
            end
            RUNNING: begin
                running = 1'b1;
                if (!ctrl_enable) begin
                    state_next = IDLE;
                end else if (frame_done && latched_limit != 32'd0
                             && frame_next == latched_limit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!ctrl_enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        overflow = running & fifo_write & fifo_full;
    end

    // State register and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            transmission_active <= 1'b0;
            loop_limit_reached  <= 1'b0;
        end else begin
            state               <= state_next;
            transmission_active <= (state_next == RUNNING);
            loop_limit_reached  <= (state_next == DONE);
        end
    end

    // Limit latch; only captured when a run starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latched_limit <= 32'd0;
        end else if (start) begin
            latched_limit <= loop_limit;
        end
    end

    // Statistics counters; a clear beats every increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count     <= 32'd0;
            overflow_count  <= 32'd0;
            overflow_sticky <= 1'b0;
            run_cycles      <= 64'd0;
            start_count     <= 32'd0;
        end else if (ctrl_clear_counters) begin
            frame_count     <= 32'd0;
            overflow_count  <= 32'd0;
            overflow_sticky <= 1'b0;
            run_cycles      <= 64'd0;
            start_count     <= 32'd0;
        end else begin
            if (start) begin
                frame_count <= 32'd0;
                run_cycles  <= 64'd0;
                start_count <= start_count + 32'd1;
            end else if (running) begin
                run_cycles <= run_cycles + 64'd1;
                if (frame_done) begin
                    frame_count <= frame_next;
                end
            end
            if (overflow) begin
                overflow_sticky <= 1'b1;
                if (overflow_count != 32'hFFFF_FFFF) begin
                    overflow_count <= overflow_count + 32'd1;
                end
            end
        end
    end

    // Word packing straight from registers, so latency stays one edge.
    always_comb begin
        status_regs_pl          = '0;
        status_regs_pl[31:0]    = {27'd0, state, overflow_sticky,
                                   transmission_active, loop_limit_reached};
        status_regs_pl[63:32]   = frame_count;
        status_regs_pl[95:64]   = latched_limit;
        status_regs_pl[127:96]  = overflow_count;
        status_regs_pl[159:128] = run_cycles[31:0];
        status_regs_pl[191:160] = run_cycles[63:32];
        status_regs_pl[223:192] = start_count;
        status_regs_pl[255:224] = VERSION;
    end

endmodule

// File: tb/tb_transmission_status_tracker.sv
// Bench for transmission_status_tracker: vector table, directed
// corner sequences and randomized traffic against a reference model.
module tb_transmission_status_tracker;

    logic         clk;
    logic         rst;
    logic         ctrl_enable;
    logic         ctrl_clear_counters;
    logic [31:0]  loop_limit;
    logic         frame_done;
    logic         fifo_write;
    logic         fifo_full;
    logic [351:0] status_regs_pl;
    logic         transmission_active;
    logic         loop_limit_reached;

    int n_checks;
    int n_errors;

    transmission_status_tracker dut (
        .clk                 (clk),
        .rst                 (rst),
        .ctrl_enable         (ctrl_enable),
        .ctrl_clear_counters (ctrl_clear_counters),
        .loop_limit          (loop_limit),
        .frame_done          (frame_done),
        .fifo_write          (fifo_write),
        .fifo_full           (fifo_full),
        .status_regs_pl      (status_regs_pl),
        .transmission_active (transmission_active),
        .loop_limit_reached  (loop_limit_reached)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 running, 2 done.
    int          m_mode;
    logic [31:0] m_limit;
    logic [31:0] m_frames;
    logic [31:0] m_ovf;
    logic        m_sticky;
    logic [63:0] m_cycles;
    logic [31:0] m_starts;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_limit = 0; m_frames = 0; m_ovf = 0;
            m_sticky = 0; m_cycles = 0; m_starts = 0;
        end else begin
            if (m_mode == 1 && fifo_write && fifo_full) begin
                m_sticky = 1;
                if (m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 1;
            end
            if (m_mode == 0) begin
                if (ctrl_enable) begin
                    m_mode = 1; m_limit = loop_limit; m_frames = 0;
                    m_cycles = 0; m_starts = m_starts + 1;
                end
            end else if (m_mode == 1) begin
                m_cycles = m_cycles + 1;
                if (frame_done) m_frames = m_frames + 1;
                if (!ctrl_enable) m_mode = 0;
                else if (frame_done && m_limit != 0 && m_frames == m_limit)
                    m_mode = 2;
            end else begin
                if (!ctrl_enable) m_mode = 0;
            end
            if (ctrl_clear_counters) begin
                m_frames = 0; m_ovf = 0; m_sticky = 0;
                m_cycles = 0; m_starts = 0;
            end
        end
    end

    function automatic logic [351:0] model_bus();
        logic [351:0] b;
        logic [1:0]   enc;
        b = '0;
        enc = 2'(m_mode);
        b[31:0]    = {27'd0, enc, m_sticky, m_mode == 1, m_mode == 2};
        b[63:32]   = m_frames;
        b[95:64]   = m_limit;
        b[127:96]  = m_ovf;
        b[159:128] = m_cycles[31:0];
        b[191:160] = m_cycles[63:32];
        b[223:192] = m_starts;
        b[255:224] = 32'h0001_0000;
        return b;
    endfunction

    function automatic logic [31:0] word(input int n);
        return status_regs_pl[32*n +: 32];
    endfunction

    task automatic check_model(input string name);
        logic [351:0] exp;
        exp = model_bus();
        n_checks++;
        if (status_regs_pl !== exp || transmission_active !== (m_mode == 1)
            || loop_limit_reached !== (m_mode == 2)) begin
            n_errors++;
            $display("FAIL %s: got bus=%h act=%b lim=%b want bus=%h act=%b lim=%b",
                     name, status_regs_pl, transmission_active,
                     loop_limit_reached, exp, m_mode == 1, m_mode == 2);
        end
    endtask

    task automatic check_eq(input string name, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic clr, input logic [31:0] lim,
                         input logic fd, input logic fw, input logic ff);
        ctrl_enable = en; ctrl_clear_counters = clr; loop_limit = lim;
        frame_done = fd; fifo_write = fw; fifo_full = ff;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        en;
        logic        clr;
        logic [31:0] lim;
        logic        fd;
        logic        fw;
        logic        ff;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[11];

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0]  = '{1'b1, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0A, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b0, 1'b0, 32'h0A, 32'd1};
        vecs[2]  = '{1'b1, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0A, 32'd1};
        vecs[3]  = '{1'b1, 1'b0, 32'd9, 1'b1, 1'b0, 1'b0, 32'h0A, 32'd2};
        vecs[4]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b0, 1'b0, 32'h11, 32'd3};
        vecs[5]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b0, 1'b0, 32'h11, 32'd3};
        vecs[6]  = '{1'b0, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 32'h00, 32'd3};
        vecs[7]  = '{1'b1, 1'b0, 32'd5, 1'b1, 1'b0, 1'b0, 32'h0A, 32'd0};
        vecs[8]  = '{1'b1, 1'b0, 32'd5, 1'b0, 1'b1, 1'b1, 32'h0E, 32'd0};
        vecs[9]  = '{1'b1, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 32'h0A, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 32'h00, 32'd0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) step();
        check_model("reset_idle");
        check_eq("reset_w0", 64'(word(0)), 64'h0);
        check_eq("reset_w7", 64'(word(7)), 64'h0001_0000);
        check_eq("reset_w1_w6", {word(1) | word(2) | word(3), word(4) | word(5) | word(6)}, 64'h0);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].lim,
                  vecs[i].fd, vecs[i].fw, vecs[i].ff);
            step();
            check_eq($sformatf("vec%0d_w0", i), 64'(word(0)), 64'(vecs[i].w0));
            check_eq($sformatf("vec%0d_w1", i), 64'(word(1)), 64'(vecs[i].w1));
            check_model($sformatf("vec%0d_model", i));
        end

        // DONE is sticky while enable stays high
        drive(1, 0, 3, 0, 0, 0);
        step();
        check_eq("run_w0", 64'(word(0)), 64'h0A);
        for (int i = 0; i < 3; i++) begin
            frame_done = 1; step();
            frame_done = 0; step();
        end
        check_eq("done_w0", 64'(word(0)), 64'h11);
        check_eq("done_w1", 64'(word(1)), 64'd3);
        check_eq("done_flag", 64'(loop_limit_reached), 64'd1);
        repeat (20) step();
        for (int i = 0; i < 5; i++) begin
            frame_done = 1; step();
            frame_done = 0; step();
        end
        check_eq("done_hold_w0", 64'(word(0)), 64'h11);
        check_eq("done_hold_w1", 64'(word(1)), 64'd3);
        check_model("done_hold");
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Unlimited mode frame counter wrap
        drive(1, 0, 0, 0, 0, 0);
        step();
        force dut.frame_count = 32'hFFFF_FFFF;
        #1;
        release dut.frame_count;
        m_frames = 32'hFFFF_FFFF;
        frame_done = 1;
        step();
        frame_done = 0;
        check_eq("wrap_w1", 64'(word(1)), 64'h0);
        check_eq("wrap_w0", 64'(word(0)), 64'h0A);
        check_model("wrap");
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Run-time counter and start count
        drive(0, 1, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0);
        step();
        repeat (100) step();
        ctrl_enable = 0;
        step();
        check_eq("runtime_w4", 64'(word(4)), 64'd101);
        check_eq("runtime_w5", 64'(word(5)), 64'd0);
        repeat (10) step();
        check_eq("runtime_frozen", 64'(word(4)), 64'd101);
        ctrl_enable = 1;
        step();
        check_eq("restart_w6", 64'(word(6)), 64'd2);
        check_eq("restart_w4", 64'(word(4)), 64'd0);

        // Overflow then clear coincident with a frame
        fifo_full = 1;
        for (int i = 0; i < 4; i++) begin
            fifo_write = 1; step();
            fifo_write = 0; step();
        end
        check_eq("ovf_w3", 64'(word(3)), 64'd4);
        check_eq("ovf_w0", 64'(word(0)), 64'h0E);
        drive(1, 1, 0, 1, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0);
        check_eq("clear_w1", 64'(word(1)), 64'd0);
        check_eq("clear_w3", 64'(word(3)), 64'd0);
        check_eq("clear_w0", 64'(word(0)), 64'h0A);
        check_model("clear");

        // Asynchronous reset between edges
        repeat (5) step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_w0", 64'(word(0)), 64'h0);
        check_eq("async_w4", 64'(word(4)), 64'h0);
        check_eq("async_w7", 64'(word(7)), 64'h0001_0000);
        check_eq("async_flags", {transmission_active, loop_limit_reached}, 64'h0);
        check_model("async_model");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 2, 0, 0, 0);
        step();
        check_eq("post_rst_w0", 64'(word(0)), 64'h0A);
        check_eq("post_rst_w6", 64'(word(6)), 64'd1);
        check_model("post_rst");

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) ctrl_enable = ~ctrl_enable;
            loop_limit = 32'($urandom_range(0, 4));
            frame_done = ($urandom_range(0, 2) == 0);
            fifo_write = $urandom_range(0, 1) == 1;
            fifo_full  = $urandom_range(0, 1) == 1;
            ctrl_clear_counters = !frame_done && ($urandom_range(0, 99) == 0);
            step();
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
